// File: rtl/core_pkg.sv
// Shared types and constants for the register scoreboard slice.
package core_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    // ID-side view of one instruction as presented to the scoreboard
    typedef struct packed {
        logic     issue;
        logic     rd_we;
        reg_idx_t rd;
        reg_idx_t rs1;
        reg_idx_t rs2;
        logic     rs1_used;
        logic     rs2_used;
    } sb_req_t;

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter for the scoreboard.
// Counts un-retired writes to one architectural register. A decrement on an
// empty counter is reported as underflow and otherwise ignored.
// Optional macro SB_RETIRE_BYPASS_EN: a same-cycle retire of the last pending
// write makes the register readable and frees a saturated slot immediately.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic clk,
    input  logic reset_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic busy_o,
    output logic src_ready_o,
    output logic full_o,
    output logic underflow_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             zero;
    logic             sat;
    logic             dec_ok;

    assign zero   = (cnt_q == '0);
    assign sat    = (cnt_q == '1);
    assign dec_ok = dec_i && !zero;

    // Next count: simultaneous valid inc and dec cancel out
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_ok && !sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_ok && !inc_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Status flags seen by the hazard logic
    always_comb begin
        busy_o      = !zero;
        underflow_o = dec_i && zero;
`ifdef SB_RETIRE_BYPASS_EN
        src_ready_o = zero || (dec_ok && (cnt_q == CNT_W'(1)));
        full_o      = sat && !dec_ok;
`else
        src_ready_o = zero;
        full_o      = sat;
`endif
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks register writes in flight between ID issue and
// WB write-back, and stalls ID on RAW hazards, per-register counter
// saturation, or when the pipeline-wide in-flight limit is reached.
// Optional macro SB_RETIRE_BYPASS_EN: a retire in the current cycle is
// treated as already freed by the hazard, saturation and total checks.
module reg_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter int unsigned CNT_W        = 2
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  ID_SB_issue_i,
    input  logic                  ID_SB_rd_we_i,
    input  logic [4:0]            ID_SB_rd_i,
    input  logic [4:0]            ID_SB_rs1_i,
    input  logic [4:0]            ID_SB_rs2_i,
    input  logic                  ID_SB_rs1_used_i,
    input  logic                  ID_SB_rs2_used_i,
    input  logic                  WB_SB_retire_i,
    input  logic [4:0]            WB_SB_rd_i,
    output logic                  SB_ID_stall_o,
    output logic [NUM_REGS-1:0]   SB_busy_o,
    output logic [CNT_W-1:0]      SB_inflight_o,
    output logic                  SB_err_o
);

    sb_req_t              req;
    logic [NUM_REGS-1:0]  busy_vec;
    logic [NUM_REGS-1:0]  ready_vec;
    logic [NUM_REGS-1:0]  full_vec;
    logic [NUM_REGS-1:0]  uflow_vec;

    logic [CNT_W-1:0]     total_q;
    logic [CNT_W-1:0]     total_d;
    logic                 err_q;
    logic                 err_d;

    logic                 we_eff;
    logic                 total_full;
    logic                 stall;
    logic                 accept;
    logic                 ret_req;
    logic                 ret_valid;

    // Bundle the ID interface into one request record
    always_comb begin
        req = '{
            issue:    ID_SB_issue_i,
            rd_we:    ID_SB_rd_we_i,
            rd:       ID_SB_rd_i,
            rs1:      ID_SB_rs1_i,
            rs2:      ID_SB_rs2_i,
            rs1_used: ID_SB_rs1_used_i,
            rs2_used: ID_SB_rs2_used_i
        };
    end

    // x0 is never tracked: constant idle status
    assign busy_vec[0]  = 1'b0;
    assign ready_vec[0] = 1'b1;
    assign full_vec[0]  = 1'b0;
    assign uflow_vec[0] = 1'b0;

    assign ret_req = WB_SB_retire_i && (WB_SB_rd_i != '0);

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk         (clk),
            .reset_i     (reset_i),
            .inc_i       (accept && (req.rd == reg_idx_t'(r))),
            .dec_i       (ret_req && (WB_SB_rd_i == reg_idx_t'(r))),
            .busy_o      (busy_vec[r]),
            .src_ready_o (ready_vec[r]),
            .full_o      (full_vec[r]),
            .underflow_o (uflow_vec[r])
        );
    end

    // Hazard detection and issue acceptance
    always_comb begin
        we_eff     = req.rd_we && (req.rd != '0);
        ret_valid  = ret_req && busy_vec[WB_SB_rd_i];
`ifdef SB_RETIRE_BYPASS_EN
        total_full = (total_q == CNT_W'(MAX_INFLIGHT)) && !ret_valid;
`else
        total_full = (total_q == CNT_W'(MAX_INFLIGHT));
`endif
        stall      = (req.rs1_used && !ready_vec[req.rs1]) ||
                     (req.rs2_used && !ready_vec[req.rs2]) ||
                     (we_eff && (full_vec[req.rd] || total_full));
        accept     = req.issue && !stall && we_eff;
    end

    // Next in-flight total and sticky error
    always_comb begin
        total_d = total_q;
        if (accept && !ret_valid) begin
            total_d = total_q + CNT_W'(1);
        end else if (ret_valid && !accept) begin
            total_d = total_q - CNT_W'(1);
        end
        err_d = err_q || (|uflow_vec) || (req.issue && stall);
    end

    // State registers; reset overrides any same-cycle issue or retire
    always_ff @(posedge clk) begin
        if (reset_i) begin
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

    assign SB_ID_stall_o = stall;
    assign SB_busy_o     = busy_vec;
    assign SB_inflight_o = total_q;
    assign SB_err_o      = err_q;

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks register-file writes that are in flight between ID issue and WB write-back.
- Stalls ID whenever a source register, or a destination needing a new slot, would create a RAW hazard or overflow a counter.
- Sits beside the register file: ID reports operand and destination indices, and WB reports retirements.
- Sequences the shared register file so that ID never reads stale data from it.

Parameters:
- MAX_INFLIGHT, 3: maximum number of un-retired register writes across the whole pipeline.
- CNT_W, 2: width of each per-register pending counter; it must satisfy 2^CNT_W - 1 >= MAX_INFLIGHT.

Ports:
- clk  in  1  core clock.
- reset_i  in  1  reset, synchronous and active-high.
- ID_SB_issue_i  in  1  ID hands an instruction to EX this cycle (give && get).
- ID_SB_rd_we_i  in  1  the issuing instruction writes rd.
- ID_SB_rd_i  in  5  destination register index.
- ID_SB_rs1_i  in  5  source 1 index.
- ID_SB_rs2_i  in  5  source 2 index.
- ID_SB_rs1_used_i  in  1  rs1 is a real operand.
- ID_SB_rs2_used_i  in  1  rs2 is a real operand.
- WB_SB_retire_i  in  1  WB writes the register file this cycle.
- WB_SB_rd_i  in  5  register being written by WB.
- SB_ID_stall_o  out  1  ID must not issue (combinational).
- SB_busy_o  out  32  bit r is set when cnt[r] != 0 (registered state, not a comb path).
- SB_inflight_o  out  CNT_W  total number of pending writes.
- SB_err_o  out  1  sticky protocol-error flag.

Behaviour:
- State:
  - cnt[1..31], each CNT_W bits.
  - total, CNT_W bits.
  - err, 1 bit.
  - x0 is never tracked: cnt[0] is hard-wired to 0, and rd=0 is treated as rd_we=0.
- Reset: when reset_i is high at a clk edge, all counters, total and err go to 0. The reset overrides any issue or retire in the same cycle.
- Reset values of outputs: SB_busy_o=0, SB_inflight_o=0, SB_err_o=0, SB_ID_stall_o=0.
- Stall (combinational from current state and ID inputs) is asserted when any of these holds:
  - rs1_used && rs1!=0 && cnt[rs1]!=0.
  - rs2_used && rs2!=0 && cnt[rs2]!=0.
  - rd_we && rd!=0 && cnt[rd]==2^CNT_W-1 (counter saturation).
  - rd_we && total==MAX_INFLIGHT.
- Accepted issue: ID_SB_issue_i && !SB_ID_stall_o && rd_we && rd!=0. It increments cnt[rd] and total at the next edge. An issue without rd_we changes no state.
- Retire: WB_SB_retire_i && WB_SB_rd_i!=0. It decrements cnt[rd] and total at the next edge.
- Simultaneous accepted issue and retire:
  - Same register: cnt is unchanged and total is unchanged.
  - Different registers: each counter updates independently and total is unchanged.
- Error cases (err is set and held until reset):
  - Retire with cnt[rd]==0: counters are left unchanged (no underflow).
  - ID_SB_issue_i while SB_ID_stall_o=1: the issue is ignored.
- Latency:
  - A hazard is visible on stall in the cycle after the producer issues.
  - It clears in the cycle after WB retires the last pending write.
- SB_busy_o and SB_inflight_o reflect the registered state, with no combinational path from the inputs.

Optional Feature:
- Macro: SB_RETIRE_BYPASS_EN.
- When defined: a source hazard on register r is suppressed in the cycle where WB_SB_retire_i && WB_SB_rd_i==r && cnt[r]==1. This saves one stall cycle, because the register file write is visible to ID in that same cycle. Saturation and total checks likewise treat a same-cycle retire as already freed.
- When undefined: stall depends only on registered state, and a hazard clears one cycle after retire.

Decomposition:
- core_pkg holds:
  - REG_ADDR_W=5 and NUM_REGS=32.
  - A typedef reg_idx_t.
  - A typedef sb_req_t: a struct of issue, rd_we, rd, rs1, rs2, rs1_used and rs2_used.
- One sub-module, sb_counter: a single up/down saturating counter with inc/dec/sat/zero/underflow outputs, instantiated 31 times by a generate loop.

Test Plan:
- Reset, then issue rd=5 at cycle 1, then rs1=5 at cycle 2 → stall=1 at cycle 2, busy[5]=1, inflight=1. Retire rd=5 at cycle 4 → stall=0 from cycle 5 (cycle 4 with SB_RETIRE_BYPASS_EN), busy=0.
- Issue rd=7 three times (MAX_INFLIGHT=3) → inflight=3; a fourth issue with rd_we → stall=1. One retire of rd=7 → inflight=2, stall drops, busy[7] stays 1 until the third retire.
- Issue rd=3 and retire rd=3 in the same cycle while cnt[3]=1 → cnt[3] stays 1, inflight unchanged, err=0.
- Retire rd=9 with cnt[9]=0 → err=1 and sticky, counters unchanged. Assert issue while stall=1 → err=1 and the issue is ignored.
- Issue with rd=0 and rd_we=1, then rs1=0 → no state change, stall=0.
- Assert reset_i while inflight=2 together with an issue and a retire in the same cycle → all state is 0 at the next edge and stall=0.
